// File: rtl/motor_arm_failsafe_if.sv
`default_nettype none
// ============================================================================
// Module      : motor_arm_failsafe_if
// Description : Bundles the receiver arm/throttle channels, IMU health
//               signals, mixer motor rates and gated motor outputs of
//               motor_arm_failsafe.
//               master : the environment (drives receiver, IMU and mixer
//                        inputs, observes gated rates and status)
//               slave  : the arming gate itself
// Revision    : 1.0 - initial release
// ============================================================================
interface motor_arm_failsafe_if #(
  parameter int REC_W   = 8,
  parameter int MOTOR_W = 8
);
  logic [REC_W-1:0]   throttle_val;
  logic [REC_W-1:0]   swa_swb_val;
  logic               imu_good;
  logic               imu_valid_strobe;
  logic [MOTOR_W-1:0] motor_1_rate_in;
  logic [MOTOR_W-1:0] motor_2_rate_in;
  logic [MOTOR_W-1:0] motor_3_rate_in;
  logic [MOTOR_W-1:0] motor_4_rate_in;
  logic [MOTOR_W-1:0] motor_1_rate_out;
  logic [MOTOR_W-1:0] motor_2_rate_out;
  logic [MOTOR_W-1:0] motor_3_rate_out;
  logic [MOTOR_W-1:0] motor_4_rate_out;
  logic               armed;
  logic               failsafe;
  logic [1:0]         state_out;

  modport master (
    output throttle_val, swa_swb_val, imu_good, imu_valid_strobe,
           motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in,
    input  motor_1_rate_out, motor_2_rate_out, motor_3_rate_out, motor_4_rate_out,
           armed, failsafe, state_out
  );

  modport slave (
    input  throttle_val, swa_swb_val, imu_good, imu_valid_strobe,
           motor_1_rate_in, motor_2_rate_in, motor_3_rate_in, motor_4_rate_in,
    output motor_1_rate_out, motor_2_rate_out, motor_3_rate_out, motor_4_rate_out,
           armed, failsafe, state_out
  );
endinterface
`default_nettype wire

// File: rtl/motor_arm_failsafe.sv
`default_nettype none
// ============================================================================
// Module      : motor_arm_failsafe
// Description : Safety gate between the motor mixer and the PWM generator.
//               Passes (clamped) mixer rates only while armed via the arm
//               switch channel with a healthy IMU. IMU loss ramps the motors
//               down one LSB per RAMP_STEP_CYCLES; disarm cuts them at once.
// Ports       : sys_clk - system clock
//               resetn  - synchronous active-low reset
//               bus     - motor_arm_failsafe_if.slave (receiver, IMU, mixer
//                         rates in; gated rates, armed, failsafe, state out)
// Revision    : 1.0 - initial release
// ============================================================================
module motor_arm_failsafe #(
  parameter int REC_W              = 8,
  parameter int MOTOR_W            = 8,
  parameter int MOTOR_MAX          = 250,
  parameter int ARM_SW_HI          = 200,
  parameter int ARM_SW_LO          = 55,
  parameter int THR_ARM_MAX        = 10,
  parameter int ARM_HOLD_CYCLES    = 38000000,
  parameter int IMU_TIMEOUT_CYCLES = 380000,
  parameter int RAMP_STEP_CYCLES   = 38000
) (
  input  wire logic           sys_clk,
  input  wire logic           resetn,
  motor_arm_failsafe_if.slave bus
);

  localparam logic [1:0] S_DISARMED = 2'b00;
  localparam logic [1:0] S_ARM_WAIT = 2'b01;
  localparam logic [1:0] S_ARMED    = 2'b10;
  localparam logic [1:0] S_FAILSAFE = 2'b11;

  localparam int HOLD_W = (ARM_HOLD_CYCLES    > 1) ? $clog2(ARM_HOLD_CYCLES)    : 1;
  localparam int WD_W   = (IMU_TIMEOUT_CYCLES > 1) ? $clog2(IMU_TIMEOUT_CYCLES) : 1;
  localparam int RAMP_W = (RAMP_STEP_CYCLES   > 1) ? $clog2(RAMP_STEP_CYCLES)   : 1;

  localparam logic [REC_W-1:0]   C_SW_HI     = REC_W'(ARM_SW_HI);
  localparam logic [REC_W-1:0]   C_SW_LO     = REC_W'(ARM_SW_LO);
  localparam logic [REC_W-1:0]   C_THR_MAX   = REC_W'(THR_ARM_MAX);
  localparam logic [MOTOR_W-1:0] C_MOTOR_MAX = MOTOR_W'(MOTOR_MAX);
  localparam logic [HOLD_W-1:0]  C_HOLD_LAST = HOLD_W'(ARM_HOLD_CYCLES - 1);
  localparam logic [WD_W-1:0]    C_WD_LAST   = WD_W'(IMU_TIMEOUT_CYCLES - 1);
  localparam logic [RAMP_W-1:0]  C_RAMP_LAST = RAMP_W'(RAMP_STEP_CYCLES - 1);

  logic [1:0]         r_state;
  logic               r_sw_released;
  logic               r_failsafe;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [WD_W-1:0]    r_wd_cnt;
  logic [RAMP_W-1:0]  r_ramp_cnt;
  logic [MOTOR_W-1:0] r_rate   [4];

  logic [MOTOR_W-1:0] w_rate_in  [4];
  logic [MOTOR_W-1:0] w_rate_lim [4];
  logic               w_sw_low;
  logic               w_arm_ok;
  logic               w_wd_expired;
  logic               w_all_zero;

  assign w_rate_in[0] = bus.motor_1_rate_in;
  assign w_rate_in[1] = bus.motor_2_rate_in;
  assign w_rate_in[2] = bus.motor_3_rate_in;
  assign w_rate_in[3] = bus.motor_4_rate_in;

  for (genvar g = 0; g < 4; g++) begin : g_lim
    assign w_rate_lim[g] = (w_rate_in[g] > C_MOTOR_MAX) ? C_MOTOR_MAX : w_rate_in[g];
  end

  assign w_sw_low = (bus.swa_swb_val < C_SW_LO);
  // sw_released forces the pilot to cycle the switch low before any arm
  // attempt, so a switch left up at power-on or after a trip cannot arm.
  assign w_arm_ok = (bus.swa_swb_val >= C_SW_HI) && (bus.throttle_val <= C_THR_MAX) &&
                    bus.imu_good && r_sw_released;
  // Counter holds TIMEOUT-1 after that many quiet cycles; one more quiet
  // cycle is the expiry. A strobe on that same cycle wins.
  assign w_wd_expired = (r_wd_cnt == C_WD_LAST) && !bus.imu_valid_strobe;
  assign w_all_zero   = (r_rate[0] == '0) && (r_rate[1] == '0) &&
                        (r_rate[2] == '0) && (r_rate[3] == '0);

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      r_state       <= S_DISARMED;
      r_sw_released <= 1'b0;
      r_failsafe    <= 1'b0;
      r_hold_cnt    <= '0;
      r_wd_cnt      <= '0;
      r_ramp_cnt    <= '0;
      for (int i = 0; i < 4; i++) r_rate[i] <= '0;
    end else begin
      // Entry into ARMED/FAILSAFE below overrides this set.
      if (w_sw_low) r_sw_released <= 1'b1;

      case (r_state)
        S_DISARMED: begin
          if (w_sw_low) r_failsafe <= 1'b0;
          if (w_arm_ok) begin
            r_state    <= S_ARM_WAIT;
            r_hold_cnt <= '0;
          end
        end

        S_ARM_WAIT: begin
          if (!w_arm_ok) begin
            r_state    <= S_DISARMED;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt == C_HOLD_LAST) begin
            r_state       <= S_ARMED;
            r_hold_cnt    <= '0;
            r_wd_cnt      <= '0;
            r_sw_released <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end

        S_ARMED: begin
          if (w_sw_low) begin
            r_state <= S_DISARMED;
            for (int i = 0; i < 4; i++) r_rate[i] <= '0;
          end else if (!bus.imu_good || w_wd_expired) begin
            // Outputs keep their last armed values as the ramp start point.
            r_state       <= S_FAILSAFE;
            r_failsafe    <= 1'b1;
            r_ramp_cnt    <= '0;
            r_sw_released <= 1'b0;
          end else begin
            for (int i = 0; i < 4; i++) r_rate[i] <= w_rate_lim[i];
            r_wd_cnt <= bus.imu_valid_strobe ? '0 : r_wd_cnt + WD_W'(1);
          end
        end

        default: begin // S_FAILSAFE
          if (w_sw_low) begin
            r_state <= S_DISARMED;
            for (int i = 0; i < 4; i++) r_rate[i] <= '0;
          end else if (w_all_zero) begin
            r_state <= S_DISARMED;
          end else if (r_ramp_cnt == C_RAMP_LAST) begin
            r_ramp_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
              if (r_rate[i] != '0) r_rate[i] <= r_rate[i] - MOTOR_W'(1);
            end
          end else begin
            r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.motor_1_rate_out = r_rate[0];
  assign bus.motor_2_rate_out = r_rate[1];
  assign bus.motor_3_rate_out = r_rate[2];
  assign bus.motor_4_rate_out = r_rate[3];
  assign bus.armed            = (r_state == S_ARMED);
  assign bus.failsafe         = r_failsafe;
  assign bus.state_out        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_arm_failsafe.sv
`default_nettype none
// ============================================================================
// Module      : tb_motor_arm_failsafe
// Description : Self-checking bench for motor_arm_failsafe with short
//               hold/timeout/ramp parameters, directed scenarios and a
//               randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_arm_failsafe;

  localparam int HOLD = 16;
  localparam int TO   = 32;
  localparam int RAMP = 4;

  logic sys_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  motor_arm_failsafe_if #(.REC_W(8), .MOTOR_W(8)) bus();

  motor_arm_failsafe #(
    .REC_W(8), .MOTOR_W(8), .MOTOR_MAX(250), .ARM_SW_HI(200), .ARM_SW_LO(55),
    .THR_ARM_MAX(10), .ARM_HOLD_CYCLES(HOLD), .IMU_TIMEOUT_CYCLES(TO),
    .RAMP_STEP_CYCLES(RAMP)
  ) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit g_strobe_en = 1'b1;
  bit g_manual    = 1'b0;

  // Reference model: mode 0 off, 1 waiting, 2 flying, 3 ramping down.
  int m_st;
  int m_out [4];
  bit m_fs;
  bit m_rel;
  int m_hold;
  int m_quiet;
  int m_ramp;

  function automatic void model_step();
    int inr [4];
    bit low, ok, rel_n;
    int q;
    inr = '{int'(bus.motor_1_rate_in), int'(bus.motor_2_rate_in),
            int'(bus.motor_3_rate_in), int'(bus.motor_4_rate_in)};
    if (!resetn) begin
      m_st = 0; m_fs = 0; m_rel = 0; m_hold = 0; m_quiet = 0; m_ramp = 0;
      foreach (m_out[i]) m_out[i] = 0;
      return;
    end
    low   = int'(bus.swa_swb_val) < 55;
    ok    = int'(bus.swa_swb_val) >= 200 && int'(bus.throttle_val) <= 10 &&
            bus.imu_good && m_rel;
    rel_n = m_rel || low;
    case (m_st)
      0: begin
        if (low) m_fs = 0;
        if (ok) begin m_st = 1; m_hold = 0; end
      end
      1: begin
        if (!ok) m_st = 0;
        else begin
          m_hold++;
          if (m_hold == HOLD) begin m_st = 2; m_quiet = 0; rel_n = 0; end
        end
      end
      2: begin
        q = bus.imu_valid_strobe ? 0 : m_quiet + 1;
        if (low) begin
          m_st = 0;
          foreach (m_out[i]) m_out[i] = 0;
        end else if (!bus.imu_good || q >= TO) begin
          m_st = 3; m_fs = 1; m_ramp = 0; rel_n = 0;
        end else begin
          m_quiet = q;
          foreach (m_out[i]) m_out[i] = (inr[i] > 250) ? 250 : inr[i];
        end
      end
      default: begin
        if (low) begin
          m_st = 0;
          foreach (m_out[i]) m_out[i] = 0;
        end else if (m_out.sum() == 0) begin
          m_st = 0;
        end else begin
          m_ramp++;
          if (m_ramp % RAMP == 0)
            foreach (m_out[i]) if (m_out[i] > 0) m_out[i]--;
        end
      end
    endcase
    m_rel = rel_n;
  endfunction

  function automatic logic [7:0] dut_out(int i);
    case (i)
      0:       return bus.motor_1_rate_out;
      1:       return bus.motor_2_rate_out;
      2:       return bus.motor_3_rate_out;
      default: return bus.motor_4_rate_out;
    endcase
  endfunction

  task automatic set_rates(input int a, input int b, input int c, input int d);
    bus.motor_1_rate_in = 8'(a);
    bus.motor_2_rate_in = 8'(b);
    bus.motor_3_rate_in = 8'(c);
    bus.motor_4_rate_in = 8'(d);
  endtask

  // One clock edge: inputs are stable across the edge, the model advances
  // with the same inputs, and outputs are observed 1 ns after the edge.
  task automatic tick();
    bus.imu_valid_strobe = g_strobe_en ? (cyc % 10 == 0) : g_manual;
    model_step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.swa_swb_val = 8'd255; bus.throttle_val = 8'd0; bus.imu_good = 1'b1;
    set_rates(0, 0, 0, 0);
    tick(); tick();
    n_checks++;
    if (bus.state_out !== 2'b00) begin n_errors++; $display("FAIL reset_state: got %b expected 00", bus.state_out); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut_out(i) !== 8'd0) begin n_errors++; $display("FAIL reset_out%0d: got %0d expected 0", i, dut_out(i)); end
    end
    n_checks++;
    if (bus.armed !== 1'b0 || bus.failsafe !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags: got armed=%b failsafe=%b expected 0 0", bus.armed, bus.failsafe);
    end
    resetn = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bus.state_out !== 2'b00) begin n_errors++; $display("FAIL switch_up_from_reset: got %b expected 00", bus.state_out); end
  endtask

  task automatic test_arm_sequence();
    bus.swa_swb_val = 8'd0;   tick();
    bus.swa_swb_val = 8'd255; tick();
    n_checks++;
    if (bus.state_out !== 2'b01) begin n_errors++; $display("FAIL arm_enter_wait: got %b expected 01", bus.state_out); end
    repeat (15) tick();
    n_checks++;
    if (bus.state_out !== 2'b01 || bus.armed !== 1'b0) begin
      n_errors++; $display("FAIL arm_hold_15: got state=%b armed=%b expected 01 0", bus.state_out, bus.armed);
    end
    tick();
    n_checks++;
    if (bus.state_out !== 2'b10 || bus.armed !== 1'b1) begin
      n_errors++; $display("FAIL arm_hold_16: got state=%b armed=%b expected 10 1", bus.state_out, bus.armed);
    end
  endtask

  task automatic test_throttle_abort();
    bus.swa_swb_val = 8'd0; tick(); tick();
    n_checks++;
    if (bus.state_out !== 2'b00) begin n_errors++; $display("FAIL disarm_switch: got %b expected 00", bus.state_out); end
    bus.swa_swb_val = 8'd255; tick();
    repeat (8) tick();
    bus.throttle_val = 8'd11; tick();
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.motor_1_rate_out !== 8'd0) begin
      n_errors++; $display("FAIL throttle_abort: got state=%b out1=%0d expected 00 0", bus.state_out, bus.motor_1_rate_out);
    end
    bus.throttle_val = 8'd0; tick();
    repeat (15) tick();
    n_checks++;
    if (bus.state_out !== 2'b01) begin n_errors++; $display("FAIL rehold_15: got %b expected 01", bus.state_out); end
    tick();
    n_checks++;
    if (bus.state_out !== 2'b10) begin n_errors++; $display("FAIL rehold_16: got %b expected 10", bus.state_out); end
  endtask

  task automatic test_passthrough();
    int e [4];
    set_rates(100, 251, 0, 250);
    tick();
    e = '{100, 250, 0, 250};
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (dut_out(i) !== 8'(e[i])) begin n_errors++; $display("FAIL pass_out%0d: got %0d expected %0d", i, dut_out(i), e[i]); end
    end
    for (int k = 0; k < 40; k++) begin
      set_rates($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(240, 255), $urandom_range(0, 255));
      tick();
      n_checks++;
      if (bus.state_out !== 2'b10) begin n_errors++; $display("FAIL pass_state: got %b expected 10", bus.state_out); end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dut_out(i) !== 8'(m_out[i])) begin n_errors++; $display("FAIL pass_rand_out%0d: got %0d expected %0d", i, dut_out(i), m_out[i]); end
      end
    end
  endtask

  task automatic test_failsafe_ramp();
    int e [4];
    bit found;
    set_rates(3, 2, 1, 0); tick();
    g_strobe_en = 1'b0; g_manual = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      n_checks++;
      if (bus.state_out !== 2'(m_st)) begin n_errors++; $display("FAIL wd_state: got %b expected %0d", bus.state_out, m_st); end
      if (bus.state_out === 2'b11) found = 1'b1;
    end
    n_checks++;
    if (!found || bus.failsafe !== 1'b1) begin n_errors++; $display("FAIL wd_failsafe: got failsafe=%b expected 1 within budget", bus.failsafe); end
    e = '{3, 2, 1, 0};
    for (int step = 0; step < 4; step++) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dut_out(i) !== 8'(e[i])) begin n_errors++; $display("FAIL ramp%0d_out%0d: got %0d expected %0d", step, i, dut_out(i), e[i]); end
      end
      if (step < 3) begin
        repeat (4) tick();
        foreach (e[i]) if (e[i] > 0) e[i]--;
      end
    end
    n_checks++;
    if (bus.state_out !== 2'b11) begin n_errors++; $display("FAIL ramp_state: got %b expected 11", bus.state_out); end
    tick();
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.failsafe !== 1'b1) begin
      n_errors++; $display("FAIL ramp_done: got state=%b failsafe=%b expected 00 1", bus.state_out, bus.failsafe);
    end
    bus.swa_swb_val = 8'd0; tick();
    n_checks++;
    if (bus.failsafe !== 1'b0) begin n_errors++; $display("FAIL failsafe_clear: got %b expected 0", bus.failsafe); end
    g_strobe_en = 1'b1;
  endtask

  task automatic test_failsafe_disarm();
    bit found;
    bus.swa_swb_val = 8'd255; repeat (17) tick();
    set_rates(20, 20, 20, 20); tick();
    g_strobe_en = 1'b0; g_manual = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (bus.state_out === 2'b11) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL fs2_entry: got state=%b expected 11 within budget", bus.state_out); end
    repeat (5) tick();
    n_checks++;
    if (bus.motor_2_rate_out !== 8'd19) begin n_errors++; $display("FAIL fs2_midramp: got %0d expected 19", bus.motor_2_rate_out); end
    bus.swa_swb_val = 8'd0; tick();
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.motor_1_rate_out !== 8'd0 || bus.motor_4_rate_out !== 8'd0 || bus.failsafe !== 1'b1) begin
      n_errors++; $display("FAIL fs2_cut: got state=%b out1=%0d out4=%0d fs=%b expected 00 0 0 1",
                           bus.state_out, bus.motor_1_rate_out, bus.motor_4_rate_out, bus.failsafe);
    end
    g_strobe_en = 1'b1;
    bus.swa_swb_val = 8'd255; tick();
    repeat (15) tick();
    n_checks++;
    if (bus.state_out !== 2'b01) begin n_errors++; $display("FAIL fs2_rearm_15: got %b expected 01", bus.state_out); end
    tick();
    n_checks++;
    if (bus.state_out !== 2'b10) begin n_errors++; $display("FAIL fs2_rearm_16: got %b expected 10", bus.state_out); end
  endtask

  task automatic test_watchdog_edge();
    bus.swa_swb_val = 8'd0; tick(); tick();
    bus.swa_swb_val = 8'd255; repeat (17) tick();
    n_checks++;
    if (bus.state_out !== 2'b10 || bus.failsafe !== 1'b0) begin
      n_errors++; $display("FAIL wde_armed: got state=%b fs=%b expected 10 0", bus.state_out, bus.failsafe);
    end
    g_strobe_en = 1'b0; g_manual = 1'b1; tick();
    g_manual = 1'b0; repeat (31) tick();
    g_manual = 1'b1; tick();
    n_checks++;
    if (bus.state_out !== 2'b10) begin n_errors++; $display("FAIL wde_strobe_on_expiry: got %b expected 10", bus.state_out); end
    g_manual = 1'b0; repeat (31) tick();
    n_checks++;
    if (bus.state_out !== 2'b10) begin n_errors++; $display("FAIL wde_31_quiet: got %b expected 10", bus.state_out); end
    bus.swa_swb_val = 8'd0; bus.imu_good = 1'b0; tick();
    n_checks++;
    if (bus.state_out !== 2'b00 || bus.failsafe !== 1'b0 || bus.motor_1_rate_out !== 8'd0) begin
      n_errors++; $display("FAIL wde_disarm_priority: got state=%b fs=%b out1=%0d expected 00 0 0",
                           bus.state_out, bus.failsafe, bus.motor_1_rate_out);
    end
    bus.imu_good = 1'b1; g_strobe_en = 1'b1;
  endtask

  task automatic test_random();
    int sw_pick [5];
    sw_pick = '{0, 40, 100, 200, 255};
    g_strobe_en = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) bus.swa_swb_val = 8'(sw_pick[$urandom_range(0, 4)]);
      if ($urandom_range(0, 19) == 0) bus.throttle_val = 8'($urandom_range(0, 12));
      if (bus.imu_good) begin if ($urandom_range(0, 149) == 0) bus.imu_good = 1'b0; end
      else if ($urandom_range(0, 9) == 0) bus.imu_good = 1'b1;
      g_manual = ($urandom_range(0, 11) == 0);
      set_rates($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      tick();
      n_checks++;
      if (bus.state_out !== 2'(m_st) || bus.armed !== (m_st == 2) || bus.failsafe !== m_fs) begin
        n_errors++; $display("FAIL rand_status @%0d: got state=%b armed=%b fs=%b expected %0d %b %b",
                             k, bus.state_out, bus.armed, bus.failsafe, m_st, (m_st == 2), m_fs);
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (dut_out(i) !== 8'(m_out[i])) begin n_errors++; $display("FAIL rand_out%0d @%0d: got %0d expected %0d", i, k, dut_out(i), m_out[i]); end
      end
    end
    g_strobe_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arm_sequence();
    test_throttle_abort();
    test_passthrough();
    test_failsafe_ramp();
    test_failsafe_disarm();
    test_watchdog_edge();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/motor_arm_failsafe.md
Name: motor_arm_failsafe

Overview:
- Safety gate between motor_mixer and pwm_generator.
- Consumes the four mixer motor rates and passes them through only when the pilot has armed the craft via the SWA/SWB channel and the IMU is healthy.
- On IMU loss it ramps the motors down to zero; on disarm it cuts them immediately.
- Runs on sys_clk; receiver and IMU inputs are already synchronous to sys_clk.

Parameters:
- REC_W, 8, receiver value width.
- MOTOR_W, 8, motor rate width.
- MOTOR_MAX, 250, ceiling applied to passed-through rates.
- ARM_SW_HI, 200, swa_swb_val at or above this = arm request.
- ARM_SW_LO, 55, swa_swb_val below this = switch released / disarm.
- THR_ARM_MAX, 10, maximum throttle_val permitted while arming.
- ARM_HOLD_CYCLES, 38000000, cycles the arm conditions must hold (1 s at 38 MHz).
- IMU_TIMEOUT_CYCLES, 380000, maximum cycles between imu_valid_strobe pulses while armed (10 ms).
- RAMP_STEP_CYCLES, 38000, cycles per 1-LSB decrement during failsafe ramp.

Ports:
- sys_clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- throttle_val  in  REC_W  receiver throttle
- swa_swb_val  in  REC_W  receiver arm switch channel
- imu_good  in  1  IMU driver healthy
- imu_valid_strobe  in  1  1-cycle pulse per new IMU sample
- motor_1_rate_in .. motor_4_rate_in  in  MOTOR_W each  mixer outputs
- motor_1_rate_out .. motor_4_rate_out  out  MOTOR_W each  gated rates to pwm_generator
- armed  out  1  high in ARMED
- failsafe  out  1  sticky failsafe indicator
- state_out  out  2  00 DISARMED, 01 ARM_WAIT, 10 ARMED, 11 FAILSAFE

Behaviour:
- Reset (sampled on posedge sys_clk with resetn low):
  - State DISARMED.
  - All motor outputs 0; armed, failsafe = 0.
  - All counters 0; sw_released = 0.
- sw_released is set whenever swa_swb_val < ARM_SW_LO. It is cleared on entry to ARMED and on entry to FAILSAFE. This prevents re-arming or arming out of reset with the switch already up.
- arm_ok is true when all of the following hold:
  - swa_swb_val >= ARM_SW_HI
  - throttle_val <= THR_ARM_MAX
  - imu_good
  - sw_released
- DISARMED:
  - Outputs 0.
  - If arm_ok, go to ARM_WAIT with hold_cnt = 0.
  - failsafe clears when swa_swb_val < ARM_SW_LO.
- ARM_WAIT:
  - Outputs 0.
  - hold_cnt increments each cycle while arm_ok.
  - If arm_ok drops, return to DISARMED (hold_cnt cleared).
  - When hold_cnt reaches ARM_HOLD_CYCLES-1 with arm_ok still true, go to ARMED next cycle. Watchdog is cleared on entry.
- ARMED:
  - Each output register is loaded with min(rate_in, MOTOR_MAX), giving 1 cycle latency.
  - armed = 1.
  - wd_cnt clears on imu_valid_strobe, otherwise increments.
- Exits from ARMED, in priority order:
  1. swa_swb_val < ARM_SW_LO → DISARMED, outputs 0 next cycle.
  2. !imu_good, or wd_cnt reaches IMU_TIMEOUT_CYCLES without a strobe → FAILSAFE. failsafe = 1, outputs hold their last ARMED values, ramp_cnt = 0.
  - A strobe in the same cycle that wd_cnt would expire clears the counter; no failsafe.
- FAILSAFE:
  - Mixer inputs ignored.
  - ramp_cnt counts to RAMP_STEP_CYCLES-1, then wraps. On wrap, each nonzero output decrements by 1, saturating at 0.
  - When all four outputs are 0, go to DISARMED; failsafe stays 1.
  - swa_swb_val < ARM_SW_LO during FAILSAFE forces outputs to 0 next cycle and DISARMED; failsafe stays 1 until the DISARMED clear rule applies.
  - Recovery of the IMU during FAILSAFE does not resume ARMED.
- Outputs are never nonzero outside ARMED/FAILSAFE.
- All comparisons are unsigned.
- Counters are sized to $clog2 of their maximum parameter and never wrap except ramp_cnt as stated.

Test Plan:
All scenarios use ARM_HOLD_CYCLES=16, IMU_TIMEOUT_CYCLES=32, RAMP_STEP_CYCLES=4, and a strobe every 10 cycles unless stated.
1. Reset with swa_swb_val=255, throttle=0, imu_good=1 → state stays 00 (sw_released=0). Drive switch 0 then 255 → state 01, reaches 10 after 16 cycles, armed=1.
2. In ARM_WAIT, raise throttle to 11 at cycle 8 → state 00, outputs 0. Lower throttle → hold restarts from 0 and needs the full 16 cycles.
3. ARMED, inputs 100/251/0/250 → outputs 100/250/0/250 one cycle later.
4. ARMED with outputs 3/2/1/0, strobes stopped → FAILSAFE at wd 32, failsafe=1. Outputs 2/1/0/0 after 4 cycles, 1/0/0/0 after 8, 0 after 12, then state 00. Setting switch to 0 clears failsafe.
5. In FAILSAFE, switch to 0 mid-ramp → outputs 0 and state 00 next cycle. Switch back to 255 (throttle 0) → requires the full arm sequence again.
6. Strobe coincident with the watchdog expiry cycle → stays ARMED. Switch low on the same cycle as imu_good falls → DISARMED, failsafe stays 0.
